// File: rtl/vector_exec_unit.sv
// Multi-cycle lane-wise vector execute stage driving the register-file write port.
// Build macro VEXEC_SAT_EN: VADD/VSUB saturate per lane; undefined, they wrap modulo 2^LANE_W.

module vector_exec_unit #(
   parameter int unsigned LANE_W = 8,
   parameter int unsigned LANES  = 24,
   parameter int unsigned LPC    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2:0]              op,
   input  logic [2:0]              dest,
   input  logic [LANE_W*LANES-1:0] r1v,
   input  logic [LANE_W*LANES-1:0] r2v,
   input  logic [20:0]             r1e,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    Reg_write,
   output logic                    desType,
   output logic [2:0]              A3,
   output logic [LANE_W*LANES-1:0] wd3v,
   output logic [20:0]             wd3e
);

   localparam int unsigned VW       = LANE_W * LANES;
   localparam int unsigned SW       = 21;
   localparam int unsigned STEPS    = LANES / LPC;
   localparam int unsigned LAST     = STEPS - 1;
   localparam int unsigned CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned IDX_W    = $clog2(VW);
   localparam int unsigned NUM_REGS = 6;

   localparam logic [2:0] OP_VADD  = 3'b000;
   localparam logic [2:0] OP_VSUB  = 3'b001;
   localparam logic [2:0] OP_VSMUL = 3'b010;
   localparam logic [2:0] OP_VXOR  = 3'b011;
   localparam logic [2:0] OP_VSUM  = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [VW-1:0]       r_res, w_res_nxt;
   logic [SW-1:0]       r_acc, w_acc_nxt;
   logic [VW-1:0]       r_a, r_b;
   logic [LANE_W-1:0]   r_s;
   logic [2:0]          r_op, r_dest;
   logic                r_legal;
   logic                r_busy, r_done, r_err, r_we, r_dtype;
   logic [2:0]          r_a3;
   logic                w_busy_nxt, w_done_nxt, w_err_nxt, w_we_nxt, w_dtype_nxt;
   logic [2:0]          w_a3_nxt;
   logic                w_accept, w_legal;
   int unsigned         w_base;
   logic [LANE_W-1:0]   w_lane_a, w_lane_b;
   logic                w_unused_r1e;

   assign w_legal      = (op <= OP_VSUM) && (dest < 3'(NUM_REGS));
   assign w_unused_r1e = ^r1e[20:LANE_W];

   // Per-lane arithmetic for the vector-result opcodes
   function automatic logic [LANE_W-1:0] lane_op(input logic [2:0]        f_op,
                                                 input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b,
                                                 input logic [LANE_W-1:0] s);
`ifdef VEXEC_SAT_EN
      logic [LANE_W:0] sum;
`endif
      lane_op = '0;
      case (f_op)
         OP_VADD: begin
`ifdef VEXEC_SAT_EN
            sum     = {1'b0, a} + {1'b0, b};
            lane_op = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
`else
            lane_op = a + b;
`endif
         end
         OP_VSUB: begin
`ifdef VEXEC_SAT_EN
            lane_op = (a < b) ? '0 : a - b;
`else
            lane_op = a - b;
`endif
         end
         OP_VSMUL: lane_op = a * s;
         OP_VXOR:  lane_op = a ^ b;
         default:  lane_op = '0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state, lane datapath and next output values
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_res_nxt   = r_res;
      w_acc_nxt   = r_acc;
      w_base      = '0;
      w_lane_a    = '0;
      w_lane_b    = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_we_nxt    = 1'b0;
      w_dtype_nxt = 1'b0;
      w_a3_nxt    = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
               w_cnt_nxt   = '0;
               w_res_nxt   = '0;
               w_acc_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_base     = 32'(r_cnt) * LPC;
            // Illegal instructions still sequence, but leave the data registers at 0
            if (r_legal) begin
               for (int unsigned j = 0; j < LPC; j++) begin
                  w_lane_a = r_a[IDX_W'((w_base + j) * LANE_W) +: LANE_W];
                  w_lane_b = r_b[IDX_W'((w_base + j) * LANE_W) +: LANE_W];
                  if (r_op == OP_VSUM)
                     w_acc_nxt = w_acc_nxt + SW'(w_lane_a);
                  else
                     w_res_nxt[IDX_W'((w_base + j) * LANE_W) +: LANE_W] =
                        lane_op(r_op, w_lane_a, w_lane_b, r_s);
               end
            end
            if (r_cnt == CNT_W'(LAST)) begin
               w_state_nxt = S_WB;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_err_nxt   = !r_legal;
               w_we_nxt    = r_legal;
               w_dtype_nxt = r_legal && (r_op != OP_VSUM);
               w_a3_nxt    = r_dest;
            end
         end
         S_WB: begin
            w_state_nxt = S_IDLE;
            w_res_nxt   = '0;
            w_acc_nxt   = '0;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_res   <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_op    <= '0;
         r_dest  <= '0;
         r_legal <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_dtype <= 1'b0;
         r_a3    <= '0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_res   <= w_res_nxt;
         r_acc   <= w_acc_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_we    <= w_we_nxt;
         r_dtype <= w_dtype_nxt;
         r_a3    <= w_a3_nxt;
         if (w_accept) begin
            r_a     <= r1v;
            r_b     <= r2v;
            r_s     <= r1e[LANE_W-1:0];
            r_op    <= op;
            r_dest  <= dest;
            r_legal <= w_legal;
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign Reg_write = r_we;
   assign desType   = r_dtype;
   assign A3        = r_a3;
   assign wd3v      = r_res;
   assign wd3e      = r_acc;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit: directed scenarios plus randomized instructions
// compared against a lane-arithmetic reference model.

module tb_vector_exec_unit;

   localparam int unsigned LANES = 24;
   localparam int unsigned VW    = 192;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [2:0]    op, dest;
   logic [VW-1:0] r1v, r2v;
   logic [20:0]   r1e;
   logic          busy, done, err, Reg_write, desType;
   logic [2:0]    A3;
   logic [VW-1:0] wd3v;
   logic [20:0]   wd3e;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0]   c_busy, c_done, c_we, c_err;
   logic [VW-1:0] c_wd3v;
   logic [20:0]   c_wd3e;
   logic [2:0]    c_a3;
   logic          c_dt, c_idle_zero;

   vector_exec_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest),
      .r1v(r1v), .r2v(r2v), .r1e(r1e),
      .busy(busy), .done(done), .err(err), .Reg_write(Reg_write),
      .desType(desType), .A3(A3), .wd3v(wd3v), .wd3e(wd3e)
   );

   always #5 clk = ~clk;

   // Reference model: unsigned lane arithmetic on plain integers
   function automatic int ref_lane(input int o, input int a, input int b, input int s);
      int t;
      case (o)
         0: begin
            t = a + b;
`ifdef VEXEC_SAT_EN
            if (t > 255) t = 255;
`endif
         end
         1: begin
            t = a - b;
`ifdef VEXEC_SAT_EN
            if (t < 0) t = 0;
`endif
         end
         2:       t = a * s;
         3:       t = a ^ b;
         default: t = 0;
      endcase
      return ((t % 256) + 256) % 256;
   endfunction

   function automatic logic [VW-1:0] ref_vec(input logic [2:0] o, input logic [VW-1:0] a,
                                             input logic [VW-1:0] b, input logic [7:0] s);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         r[8*i +: 8] = 8'(ref_lane(int'(o), int'(a[8*i +: 8]), int'(b[8*i +: 8]), int'(s)));
      return r;
   endfunction

   function automatic logic [20:0] ref_sum(input logic [VW-1:0] a);
      int acc;
      acc = 0;
      for (int i = 0; i < LANES; i++) acc += int'(a[8*i +: 8]);
      return 21'(acc);
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < 6; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Issue one instruction and record cycles 1..10 after acceptance; optional stray start at cycle inj
   task automatic run_op(input logic [2:0] o, input logic [2:0] d, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [20:0] e, input int inj);
      op = o; dest = d; r1v = a; r2v = b; r1e = e; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom); dest = 3'($urandom); r1v = rand_vec(); r2v = rand_vec(); r1e = 21'($urandom);
      c_busy = '0; c_done = '0; c_we = '0; c_err = '0;
      c_wd3v = 'x; c_wd3e = 'x; c_a3 = 'x; c_dt = 1'bx; c_idle_zero = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         c_busy[cyc] = busy; c_done[cyc] = done; c_we[cyc] = Reg_write; c_err[cyc] = err;
         if (done) begin c_wd3v = wd3v; c_wd3e = wd3e; c_a3 = A3; c_dt = desType; end
         if (cyc == 8) c_idle_zero = (wd3v == '0) && (wd3e == '0) && (A3 == '0) && !desType;
         start = (cyc == inj);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op = 3'd0; dest = 3'd1; r1v = rand_vec(); r2v = rand_vec();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, err, Reg_write, desType, A3} !== 8'h00)
         $display("FAIL reset_ctrl got=%b exp=00000000", {busy, done, err, Reg_write, desType, A3});
      else n_pass++;
      n_checks++;
      if (wd3v !== '0 || wd3e !== '0) $display("FAIL reset_data got=%h/%h exp=0", wd3v, wd3e);
      else n_pass++;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vadd_basic();
      logic [VW-1:0] a, b;
      a = {LANES{8'h10}}; b = {LANES{8'h05}};
      run_op(3'd0, 3'd2, a, b, 21'd0, 0);
      n_checks++; if (c_wd3v !== {LANES{8'h15}}) $display("FAIL vadd_wd3v got=%h exp=%h", c_wd3v, {LANES{8'h15}}); else n_pass++;
      n_checks++; if (c_a3 !== 3'd2) $display("FAIL vadd_a3 got=%0d exp=2", c_a3); else n_pass++;
      n_checks++; if (c_dt !== 1'b1) $display("FAIL vadd_destype got=%b exp=1", c_dt); else n_pass++;
      n_checks++; if (c_busy !== 32'h0000_00FE) $display("FAIL vadd_busy got=%h exp=000000fe", c_busy); else n_pass++;
      n_checks++; if (c_done !== 32'h0000_0080) $display("FAIL vadd_done got=%h exp=00000080", c_done); else n_pass++;
      n_checks++; if (c_we !== 32'h0000_0080) $display("FAIL vadd_regwrite got=%h exp=00000080", c_we); else n_pass++;
      n_checks++; if (c_err !== 32'h0) $display("FAIL vadd_err got=%h exp=0", c_err); else n_pass++;
      n_checks++; if (c_idle_zero !== 1'b1) $display("FAIL vadd_idle_zero got=%b exp=1", c_idle_zero); else n_pass++;
   endtask

   task automatic test_saturation();
      logic [VW-1:0] a, b;
      logic [7:0]    exp_add, exp_sub;
`ifdef VEXEC_SAT_EN
      exp_add = 8'hFF; exp_sub = 8'h00;
`else
      exp_add = 8'h10; exp_sub = 8'hFC;
`endif
      a = rand_vec(); b = rand_vec(); a[7:0] = 8'hF0; b[7:0] = 8'h20;
      run_op(3'd0, 3'd0, a, b, 21'd0, 0);
      n_checks++; if (c_wd3v[7:0] !== exp_add) $display("FAIL sat_vadd_lane0 got=%h exp=%h", c_wd3v[7:0], exp_add); else n_pass++;
      n_checks++; if (c_wd3v !== ref_vec(3'd0, a, b, 8'd0)) $display("FAIL sat_vadd_vec got=%h exp=%h", c_wd3v, ref_vec(3'd0, a, b, 8'd0)); else n_pass++;
      a = rand_vec(); b = rand_vec(); a[7:0] = 8'h05; b[7:0] = 8'h09;
      run_op(3'd1, 3'd5, a, b, 21'd0, 0);
      n_checks++; if (c_wd3v[7:0] !== exp_sub) $display("FAIL sat_vsub_lane0 got=%h exp=%h", c_wd3v[7:0], exp_sub); else n_pass++;
      n_checks++; if (c_wd3v !== ref_vec(3'd1, a, b, 8'd0)) $display("FAIL sat_vsub_vec got=%h exp=%h", c_wd3v, ref_vec(3'd1, a, b, 8'd0)); else n_pass++;
   endtask

   task automatic test_vsum();
      run_op(3'd4, 3'd4, {LANES{8'hFF}}, rand_vec(), 21'd0, 0);
      n_checks++; if (c_wd3e !== 21'd6120) $display("FAIL vsum_wd3e got=%0d exp=6120", c_wd3e); else n_pass++;
      n_checks++; if (c_dt !== 1'b0) $display("FAIL vsum_destype got=%b exp=0", c_dt); else n_pass++;
      n_checks++; if (c_a3 !== 3'd4) $display("FAIL vsum_a3 got=%0d exp=4", c_a3); else n_pass++;
      n_checks++; if (c_wd3v !== '0) $display("FAIL vsum_wd3v got=%h exp=0", c_wd3v); else n_pass++;
   endtask

   task automatic test_vsmul_stray_start();
      logic [VW-1:0] a, exp_v;
      for (int i = 0; i < LANES; i++) begin
         a[8*i +: 8] = 8'(i);
         exp_v[8*i +: 8] = 8'(3 * i);
      end
      run_op(3'd2, 3'd3, a, rand_vec(), 21'h1FFF03, 3);
      n_checks++; if (c_wd3v !== exp_v) $display("FAIL vsmul_wd3v got=%h exp=%h", c_wd3v, exp_v); else n_pass++;
      n_checks++; if (c_done !== 32'h0000_0080) $display("FAIL vsmul_single_done got=%h exp=00000080", c_done); else n_pass++;
      n_checks++; if (c_busy !== 32'h0000_00FE) $display("FAIL vsmul_busy got=%h exp=000000fe", c_busy); else n_pass++;
   endtask

   task automatic test_illegal();
      run_op(3'b110, 3'd1, rand_vec(), rand_vec(), 21'h3, 0);
      n_checks++; if (c_err !== 32'h0000_0080) $display("FAIL ill_op_err got=%h exp=00000080", c_err); else n_pass++;
      n_checks++; if (c_done !== 32'h0000_0080) $display("FAIL ill_op_done got=%h exp=00000080", c_done); else n_pass++;
      n_checks++; if (c_we !== 32'h0) $display("FAIL ill_op_regwrite got=%h exp=0", c_we); else n_pass++;
      n_checks++; if (c_wd3v !== '0 || c_wd3e !== '0) $display("FAIL ill_op_data got=%h/%h exp=0", c_wd3v, c_wd3e); else n_pass++;
      run_op(3'd0, 3'd7, rand_vec(), rand_vec(), 21'h0, 0);
      n_checks++; if (c_err !== 32'h0000_0080) $display("FAIL ill_dest_err got=%h exp=00000080", c_err); else n_pass++;
      n_checks++; if (c_we !== 32'h0) $display("FAIL ill_dest_regwrite got=%h exp=0", c_we); else n_pass++;
      n_checks++; if (c_wd3v !== '0) $display("FAIL ill_dest_wd3v got=%h exp=0", c_wd3v); else n_pass++;
   endtask

   task automatic test_reset_abort();
      logic          seen_done, seen_we, cyc4_busy, cyc5_zero;
      logic [VW-1:0] a, b;
      seen_done = 1'b0; seen_we = 1'b0; cyc4_busy = 1'b0; cyc5_zero = 1'b0;
      op = 3'd0; dest = 3'd1; r1v = rand_vec(); r2v = rand_vec(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (cyc == 4) cyc4_busy = busy;
         if (cyc == 5) cyc5_zero = ({busy, done, err, Reg_write, desType, A3} == 8'h00) && (wd3v == '0) && (wd3e == '0);
         if (cyc >= 5) begin seen_done |= done; seen_we |= Reg_write; end
         rst = (cyc == 4);
         @(posedge clk); #1;
      end
      n_checks++; if (cyc4_busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", cyc4_busy); else n_pass++;
      n_checks++; if (cyc5_zero !== 1'b1) $display("FAIL abort_outputs_zero got=%b exp=1", cyc5_zero); else n_pass++;
      n_checks++; if ({seen_done, seen_we} !== 2'b00) $display("FAIL abort_no_write got=%b exp=00", {seen_done, seen_we}); else n_pass++;
      a = rand_vec(); b = rand_vec();
      run_op(3'd3, 3'd5, a, b, 21'd0, 0);
      n_checks++; if (c_wd3v !== ref_vec(3'd3, a, b, 8'd0)) $display("FAIL abort_restart_wd3v got=%h exp=%h", c_wd3v, ref_vec(3'd3, a, b, 8'd0)); else n_pass++;
      n_checks++; if (c_we !== 32'h0000_0080) $display("FAIL abort_restart_regwrite got=%h exp=00000080", c_we); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] a, b;
      a = rand_vec(); b = rand_vec();
      op = 3'd1; dest = 3'd3; r1v = a; r2v = b; r1e = 21'd0; start = 1'b1;
      @(posedge clk); #1;
      c_busy = '0; c_done = '0; c_we = '0; c_wd3v = 'x;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         c_busy[cyc] = busy; c_done[cyc] = done; c_we[cyc] = Reg_write;
         if (done) c_wd3v = wd3v;
         if (cyc >= 9) start = 1'b0;
         @(posedge clk); #1;
      end
      n_checks++; if (c_done !== 32'h0000_8080) $display("FAIL b2b_done got=%h exp=00008080", c_done); else n_pass++;
      n_checks++; if (c_busy !== 32'h0000_FEFE) $display("FAIL b2b_busy got=%h exp=0000fefe", c_busy); else n_pass++;
      n_checks++; if (c_we !== 32'h0000_8080) $display("FAIL b2b_regwrite got=%h exp=00008080", c_we); else n_pass++;
      n_checks++; if (c_wd3v !== ref_vec(3'd1, a, b, 8'd0)) $display("FAIL b2b_wd3v got=%h exp=%h", c_wd3v, ref_vec(3'd1, a, b, 8'd0)); else n_pass++;
   endtask

   task automatic test_random();
      logic [2:0]    o, d;
      logic [VW-1:0] a, b, exp_v;
      logic [20:0]   e, exp_e;
      logic          legal;
      for (int n = 0; n < 24; n++) begin
         o = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) o = 3'($urandom_range(0, 4));
         d = 3'($urandom_range(0, 7));
         a = rand_vec(); b = rand_vec(); e = 21'($urandom);
         legal = (o <= 3'd4) && (d <= 3'd5);
         exp_v = (legal && o != 3'd4) ? ref_vec(o, a, b, e[7:0]) : '0;
         exp_e = (legal && o == 3'd4) ? ref_sum(a) : '0;
         run_op(o, d, a, b, e, 0);
         n_checks++; if (c_wd3v !== exp_v) $display("FAIL rnd%0d_wd3v op=%0d got=%h exp=%h", n, o, c_wd3v, exp_v); else n_pass++;
         n_checks++; if (c_wd3e !== exp_e) $display("FAIL rnd%0d_wd3e got=%0d exp=%0d", n, c_wd3e, exp_e); else n_pass++;
         n_checks++; if (c_dt !== (legal && o != 3'd4)) $display("FAIL rnd%0d_destype got=%b exp=%b", n, c_dt, legal && o != 3'd4); else n_pass++;
         n_checks++; if (c_done !== 32'h80) $display("FAIL rnd%0d_done got=%h exp=00000080", n, c_done); else n_pass++;
         n_checks++; if (c_we !== (legal ? 32'h80 : 32'h0)) $display("FAIL rnd%0d_regwrite got=%h legal=%b", n, c_we, legal); else n_pass++;
         n_checks++; if (c_err !== (legal ? 32'h0 : 32'h80)) $display("FAIL rnd%0d_err got=%h legal=%b", n, c_err, legal); else n_pass++;
         n_checks++; if (c_idle_zero !== 1'b1) $display("FAIL rnd%0d_idle_zero got=%b exp=1", n, c_idle_zero); else n_pass++;
         if (legal) begin
            n_checks++; if (c_a3 !== d) $display("FAIL rnd%0d_a3 got=%0d exp=%0d", n, c_a3, d); else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; dest = '0; r1v = '0; r2v = '0; r1e = '0;
      test_reset();
      test_vadd_basic();
      test_saturation();
      test_vsum();
      test_vsmul_stray_start();
      test_illegal();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
